// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte-wide memory bus responder. Decodes each cycle's
// address into on-chip RAM or an 8-byte I/O window (TX FIFO, RX holding
// register, status byte, sticky halt flag). Read data is registered and
// arrives one cycle after the address is sampled.
module mem_bus_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [31:0] mem_ram_addr,
  input  logic [7:0]  mem_ram_data,
  input  logic        mem_ram_wr,
  output logic [7:0]  ram_data,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready,
  input  logic        io_rx_valid,
  input  logic [7:0]  io_rx_data,
  output logic        io_rx_ready,
  output logic        halt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  // Address decode
  logic                  is_io;
  logic [2:0]            io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;

  assign is_io   = (mem_ram_addr[31:3] == IO_BASE[31:3]);
  assign io_off  = mem_ram_addr[2:0];
  assign ram_idx = mem_ram_addr[ADDR_WIDTH-1:0];

  // Storage
  logic [7:0] mem      [2**ADDR_WIDTH];
  logic [7:0] fifo_mem [FIFO_DEPTH];

  // TX FIFO pointers: one extra wrap bit distinguishes full from empty
  logic [PW:0] wptr, rptr;
  logic        tx_empty, tx_full;
  logic        tx_push_req, tx_push, tx_pop;

  // RX holding register and halt flag
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_capture, rx_pop, halt_set;

  logic       ram_we;
  logic [7:0] rd_byte;

  assign tx_empty    = (wptr == rptr);
  assign tx_full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign io_tx_valid = !tx_empty && rdy;
  assign io_tx_data  = fifo_mem[rptr[PW-1:0]];
  assign tx_pop      = io_tx_valid && io_tx_ready;
  assign tx_push_req = rdy && is_io && mem_ram_wr && (io_off == 3'd0);
  // A push into a full FIFO survives only when the head leaves on the same edge
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);

  assign io_rx_ready = !rx_valid && rdy;
  assign rx_capture  = io_rx_valid && io_rx_ready;
  assign rx_pop      = rdy && is_io && !mem_ram_wr && (io_off == 3'd0) && rx_valid;
  assign halt_set    = rdy && is_io && mem_ram_wr && (io_off == 3'd4);

  assign ram_we      = rdy && !is_io && mem_ram_wr;

  // Select the byte to return for this cycle's access
  always_comb begin
    // NOTE: default first so every path assigns rd_byte and no latch is inferred.
    rd_byte = 8'h00;
    if (!mem_ram_wr) begin
      if (!is_io) begin
        rd_byte = mem[ram_idx];
      end else begin
        case (io_off)
          3'd0:    rd_byte = rx_valid ? rx_data : 8'h00;
          3'd4:    rd_byte = {5'b0, halt, rx_valid, tx_full};
          default: rd_byte = 8'h00;
        endcase
      end
    end
  end

  // RAM and FIFO storage writes
  // NOTE: storage arrays carry no reset; reset only clears the pointers/flags that give them meaning.
  always_ff @(posedge clk) begin
    if (ram_we)  mem[ram_idx]              <= mem_ram_data;
    if (tx_push) fifo_mem[wptr[PW-1:0]]    <= mem_ram_data;
  end

  // Registered read data; holds while rdy is low
  // NOTE: non-blocking assignments for all sequential state so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_data <= 8'h00;
    end else if (rdy) begin
      ram_data <= rd_byte;
    end
  end

  // TX FIFO pointer update (push and pop may coincide)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (tx_push) wptr <= wptr + 1'b1;
      if (tx_pop)  rptr <= rptr + 1'b1;
    end
  end

  // RX holding register: capture from producer, clear on CPU read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else if (rx_capture) begin
      rx_valid <= 1'b1;
      rx_data  <= io_rx_data;
    end else if (rx_pop) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt <= 1'b0;
    end else if (halt_set) begin
      halt <= 1'b1;
    end
  end

endmodule
